// File: rtl/ctl_bus_arbiter_mux.sv
// ctl_bus_arbiter_mux: arbitrates NUM_MASTERS masters for one registered control bus.
// The winner's control lines are registered onto ctl_out; IDLE_VALUE is driven while
// the bus is unowned, forced idle or in the DEAD_CYCLES turnaround between owners.
//
// Optional feature macro: CTLMUX_TIMEOUT_EN
//   defined   - ownership is limited to MAX_HOLD cycles; a forced release pulses
//               timeout and blocks that master until it drops req for a cycle.
//   undefined - no hold counter, timeout tied low, MAX_HOLD unused.
//
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   req             per-master bus request
//   ctl_in          master i control lines at [i*CTL_WIDTH +: CTL_WIDTH]
//   force_idle      hold the bus at IDLE_VALUE and suppress new grants
//   gnt             one-hot grant (or zero)
//   ctl_out         registered control bus
//   owner_idx       current/last owner (also the round-robin pointer)
//   bus_busy        high while a master owns the bus
//   timeout         one-cycle pulse on a forced release
module ctl_bus_arbiter_mux #(
  parameter int unsigned           NUM_MASTERS = 4,
  parameter int unsigned           CTL_WIDTH   = 5,
  parameter logic [CTL_WIDTH-1:0]  IDLE_VALUE  = '0,
  parameter int unsigned           DEAD_CYCLES = 1,
  parameter int unsigned           ROUND_ROBIN = 1,
  parameter int unsigned           MAX_HOLD    = 256
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_MASTERS-1:0]           req,
  input  logic [NUM_MASTERS*CTL_WIDTH-1:0] ctl_in,
  input  logic                             force_idle,
  output logic [NUM_MASTERS-1:0]           gnt,
  output logic [CTL_WIDTH-1:0]             ctl_out,
  output logic [$clog2(NUM_MASTERS)-1:0]   owner_idx,
  output logic                             bus_busy,
  output logic                             timeout
);

  localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       turn_cnt_q, turn_cnt_d;
  logic [NUM_MASTERS-1:0] gnt_d;
  logic [CTL_WIDTH-1:0]   ctl_d;
  logic [IDX_W-1:0]       owner_d;
  logic                   busy_d;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic                   hold_expired;
  logic [CTL_WIDTH-1:0]   ctl_arr [NUM_MASTERS];

`ifdef CTLMUX_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [NUM_MASTERS-1:0] blocked_q, blocked_d;
  logic                   timeout_d;
`endif

  // Unpacked view of the flattened master control lines
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      ctl_arr[i] = ctl_in[i*CTL_WIDTH +: CTL_WIDTH];
    end
  end

`ifdef CTLMUX_TIMEOUT_EN
  assign eligible     = req & ~blocked_q;
  assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD));
`else
  assign eligible     = req;
  assign hold_expired = 1'b0;
`endif

  // Winner search: round-robin starts after the last owner, fixed starts at 0
  always_comb begin
    int unsigned cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (ROUND_ROBIN != 0) begin
        cand = 32'(owner_idx) + 32'd1 + 32'(k);
        if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      end else begin
        cand = 32'(k);
      end
      if (!win_found && eligible[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    gnt_d      = gnt;
    ctl_d      = ctl_out;
    owner_d    = owner_idx;
    busy_d     = bus_busy;
`ifdef CTLMUX_TIMEOUT_EN
    hold_d     = hold_q;
    blocked_d  = blocked_q & req;  // a blocked master is freed by dropping req
    timeout_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        ctl_d  = IDLE_VALUE;
        if (win_found && !force_idle) begin
          state_d = ST_OWNED;
          gnt_d   = NUM_MASTERS'(1) << win_idx;
          owner_d = win_idx;
          busy_d  = 1'b1;
          ctl_d   = ctl_arr[win_idx];
`ifdef CTLMUX_TIMEOUT_EN
          hold_d  = HOLD_W'(1);
`endif
        end
      end
      ST_OWNED: begin
        // Release (req drop or hold limit) wins over force_idle
        if (!req[owner_idx] || hold_expired) begin
          gnt_d      = '0;
          busy_d     = 1'b0;
          ctl_d      = IDLE_VALUE;
          turn_cnt_d = CNT_W'(DEAD_CYCLES);
          state_d    = (DEAD_CYCLES == 0) ? ST_IDLE : ST_TURN;
`ifdef CTLMUX_TIMEOUT_EN
          if (req[owner_idx]) begin
            timeout_d            = 1'b1;
            blocked_d[owner_idx] = 1'b1;
          end
`endif
        end else begin
          ctl_d = force_idle ? IDLE_VALUE : ctl_arr[owner_idx];
`ifdef CTLMUX_TIMEOUT_EN
          hold_d = hold_q + HOLD_W'(1);
`endif
        end
      end
      ST_TURN: begin
        gnt_d      = '0;
        busy_d     = 1'b0;
        ctl_d      = IDLE_VALUE;
        turn_cnt_d = turn_cnt_q - CNT_W'(1);
        if (turn_cnt_q <= CNT_W'(1)) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ctl_d   = IDLE_VALUE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      turn_cnt_q <= '0;
      gnt        <= '0;
      ctl_out    <= IDLE_VALUE;
      owner_idx  <= '0;
      bus_busy   <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      gnt        <= gnt_d;
      ctl_out    <= ctl_d;
      owner_idx  <= owner_d;
      bus_busy   <= busy_d;
    end
  end

`ifdef CTLMUX_TIMEOUT_EN
  // Hold counter, timeout pulse and post-timeout block mask
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q    <= '0;
      blocked_q <= '0;
      timeout   <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      blocked_q <= blocked_d;
      timeout   <= timeout_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ctl_bus_arbiter_mux.sv
// Testbench for ctl_bus_arbiter_mux: a round-robin instance and a fixed-priority
// instance share stimulus; expected outputs are queued as stimulus is applied and
// compared against the captured outputs of the instance under test.
module tb_ctl_bus_arbiter_mux;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req;
  logic [19:0] ctl_in;
  logic        force_idle;
  logic [4:0]  cv [4];

  logic [3:0] gnt_rr, gnt_fx;
  logic [4:0] ctl_rr, ctl_fx;
  logic [1:0] own_rr, own_fx;
  logic       busy_rr, busy_fx, to_rr, to_fx;

  int vec;
  int miss;

  logic [12:0] sb_exp [$];
  logic [12:0] sb_obs [$];

  assign ctl_in = {cv[3], cv[2], cv[1], cv[0]};

  ctl_bus_arbiter_mux #(
    .NUM_MASTERS(4), .CTL_WIDTH(5), .IDLE_VALUE(5'h00),
    .DEAD_CYCLES(1), .ROUND_ROBIN(1), .MAX_HOLD(256)
  ) u_rr (
    .clock(clock), .reset_n(reset_n), .req(req), .ctl_in(ctl_in),
    .force_idle(force_idle), .gnt(gnt_rr), .ctl_out(ctl_rr),
    .owner_idx(own_rr), .bus_busy(busy_rr), .timeout(to_rr)
  );

  ctl_bus_arbiter_mux #(
    .NUM_MASTERS(4), .CTL_WIDTH(5), .IDLE_VALUE(5'h00),
    .DEAD_CYCLES(1), .ROUND_ROBIN(0), .MAX_HOLD(8)
  ) u_fx (
    .clock(clock), .reset_n(reset_n), .req(req), .ctl_in(ctl_in),
    .force_idle(force_idle), .gnt(gnt_fx), .ctl_out(ctl_fx),
    .owner_idx(own_fx), .bus_busy(busy_fx), .timeout(to_fx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [12:0] mk(input logic [3:0] g, input logic [4:0] c,
                                     input logic [1:0] o, input logic b, input logic t);
    return {g, c, o, b, t};
  endfunction

  function automatic logic [12:0] obs_rr();
    return {gnt_rr, ctl_rr, own_rr, busy_rr, to_rr};
  endfunction

  function automatic logic [12:0] obs_fx();
    return {gnt_fx, ctl_fx, own_fx, busy_fx, to_fx};
  endfunction

  function automatic string fmt(input logic [12:0] v);
    return $sformatf("gnt=%b ctl=%h own=%0d busy=%b to=%b",
                     v[12:9], v[8:4], v[3:2], v[1], v[0]);
  endfunction

  // Apply one cycle of stimulus, queue its expected result, capture the DUT output
  task automatic drive(input logic [3:0] r, input logic f, input logic [12:0] e,
                       input bit use_fx);
    req        = r;
    force_idle = f;
    sb_exp.push_back(e);
    @(posedge clock);
    @(negedge clock);
    sb_obs.push_back(use_fx ? obs_fx() : obs_rr());
  endtask

  task automatic idle_cycles(input int n);
    req        = 4'b0000;
    force_idle = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [12:0] o;
    logic [12:0] e;
    logic [12:0] z;
    z          = mk(4'b0000, 5'h00, 2'd0, 1'b0, 1'b0);
    reset_n    = 1'b0;
    req        = 4'b0000;
    force_idle = 1'b0;
    repeat (2) @(negedge clock);
    o = obs_rr(); vec++;
    if (o !== z) begin miss++; $display("FAIL reset_held: got %s want %s", fmt(o), fmt(z)); end
    reset_n = 1'b1;
    @(negedge clock);
    o = obs_rr(); vec++;
    if (o !== z) begin miss++; $display("FAIL reset_rr: got %s want %s", fmt(o), fmt(z)); end
    o = obs_fx(); vec++;
    if (o !== z) begin miss++; $display("FAIL reset_fx: got %s want %s", fmt(o), fmt(z)); end
    drive(4'b0001, 1'b0, mk(4'b0001, 5'h11, 2'd0, 1'b1, 1'b0), 1'b0);
    e = sb_exp.pop_front(); o = sb_obs.pop_front(); vec++;
    if (o !== e) begin miss++; $display("FAIL reset_pre_grant: got %s want %s", fmt(o), fmt(e)); end
    #2 reset_n = 1'b0;
    #1;
    o = obs_rr(); vec++;
    if (o !== z) begin miss++; $display("FAIL reset_async_rr: got %s want %s", fmt(o), fmt(z)); end
    o = obs_fx(); vec++;
    if (o !== z) begin miss++; $display("FAIL reset_async_fx: got %s want %s", fmt(o), fmt(z)); end
    req = 4'b0000;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    o = obs_rr(); vec++;
    if (o !== z) begin miss++; $display("FAIL reset_after: got %s want %s", fmt(o), fmt(z)); end
  endtask

  task automatic test_single();
    logic [12:0] o;
    logic [12:0] e;
    drive(4'b0010, 1'b0, mk(4'b0010, 5'h15, 2'd1, 1'b1, 1'b0), 1'b0);
    cv[1] = 5'h07;
    drive(4'b0010, 1'b0, mk(4'b0010, 5'h07, 2'd1, 1'b1, 1'b0), 1'b0);
    cv[1] = 5'h15;
    drive(4'b0000, 1'b0, mk(4'b0000, 5'h00, 2'd1, 1'b0, 1'b0), 1'b0);
    drive(4'b0000, 1'b0, mk(4'b0000, 5'h00, 2'd1, 1'b0, 1'b0), 1'b0);
    for (int i = 0; sb_exp.size() != 0; i++) begin
      e = sb_exp.pop_front(); vec++;
      o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 13'bx;
      if (o !== e) begin miss++; $display("FAIL single step %0d: got %s want %s", i, fmt(o), fmt(e)); end
    end
    idle_cycles(3);
  endtask

  task automatic test_round_robin();
    logic [12:0] o;
    logic [12:0] e;
    logic [3:0]  rq [16];
    logic [12:0] ex [16];
    rq = '{4'b1000, 4'b0000, 4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1101,
           4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b1011, 4'b0111, 4'b0111, 4'b0111};
    ex[0]  = mk(4'b1000, 5'h1e, 2'd3, 1'b1, 1'b0);
    ex[1]  = mk(4'b0000, 5'h00, 2'd3, 1'b0, 1'b0);
    ex[2]  = mk(4'b0000, 5'h00, 2'd3, 1'b0, 1'b0);
    ex[3]  = mk(4'b0001, 5'h11, 2'd0, 1'b1, 1'b0);
    ex[4]  = mk(4'b0000, 5'h00, 2'd0, 1'b0, 1'b0);
    ex[5]  = mk(4'b0000, 5'h00, 2'd0, 1'b0, 1'b0);
    ex[6]  = mk(4'b0010, 5'h15, 2'd1, 1'b1, 1'b0);
    ex[7]  = mk(4'b0000, 5'h00, 2'd1, 1'b0, 1'b0);
    ex[8]  = mk(4'b0000, 5'h00, 2'd1, 1'b0, 1'b0);
    ex[9]  = mk(4'b0100, 5'h0a, 2'd2, 1'b1, 1'b0);
    ex[10] = mk(4'b0000, 5'h00, 2'd2, 1'b0, 1'b0);
    ex[11] = mk(4'b0000, 5'h00, 2'd2, 1'b0, 1'b0);
    ex[12] = mk(4'b1000, 5'h1e, 2'd3, 1'b1, 1'b0);
    ex[13] = mk(4'b0000, 5'h00, 2'd3, 1'b0, 1'b0);
    ex[14] = mk(4'b0000, 5'h00, 2'd3, 1'b0, 1'b0);
    ex[15] = mk(4'b0001, 5'h11, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) drive(rq[i], 1'b0, ex[i], 1'b0);
    for (int i = 0; sb_exp.size() != 0; i++) begin
      e = sb_exp.pop_front(); vec++;
      o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 13'bx;
      if (o !== e) begin miss++; $display("FAIL round_robin step %0d: got %s want %s", i, fmt(o), fmt(e)); end
    end
    idle_cycles(3);
  endtask

  task automatic test_fixed_priority();
    logic [12:0] o;
    logic [12:0] e;
    logic [3:0]  rq [12];
    logic [12:0] ex [12];
    rq = '{4'b1100, 4'b1100, 4'b1100, 4'b1000, 4'b1100, 4'b1100,
           4'b1000, 4'b1000, 4'b1000, 4'b0110, 4'b0110, 4'b0110};
    ex[0]  = mk(4'b0100, 5'h0a, 2'd2, 1'b1, 1'b0);
    ex[1]  = mk(4'b0100, 5'h0a, 2'd2, 1'b1, 1'b0);
    ex[2]  = mk(4'b0100, 5'h0a, 2'd2, 1'b1, 1'b0);
    ex[3]  = mk(4'b0000, 5'h00, 2'd2, 1'b0, 1'b0);
    ex[4]  = mk(4'b0000, 5'h00, 2'd2, 1'b0, 1'b0);
    ex[5]  = mk(4'b0100, 5'h0a, 2'd2, 1'b1, 1'b0);
    ex[6]  = mk(4'b0000, 5'h00, 2'd2, 1'b0, 1'b0);
    ex[7]  = mk(4'b0000, 5'h00, 2'd2, 1'b0, 1'b0);
    ex[8]  = mk(4'b1000, 5'h1e, 2'd3, 1'b1, 1'b0);
    ex[9]  = mk(4'b0000, 5'h00, 2'd3, 1'b0, 1'b0);
    ex[10] = mk(4'b0000, 5'h00, 2'd3, 1'b0, 1'b0);
    ex[11] = mk(4'b0010, 5'h15, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(rq[i], 1'b0, ex[i], 1'b1);
    for (int i = 0; sb_exp.size() != 0; i++) begin
      e = sb_exp.pop_front(); vec++;
      o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 13'bx;
      if (o !== e) begin miss++; $display("FAIL fixed_priority step %0d: got %s want %s", i, fmt(o), fmt(e)); end
    end
    idle_cycles(3);
  endtask

  task automatic test_force_idle();
    logic [12:0] o;
    logic [12:0] e;
    logic [3:0]  rq [9];
    logic        fi [9];
    logic [12:0] ex [9];
    rq = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000};
    fi = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ex[0] = mk(4'b0010, 5'h15, 2'd1, 1'b1, 1'b0);
    ex[1] = mk(4'b0010, 5'h00, 2'd1, 1'b1, 1'b0);
    ex[2] = mk(4'b0010, 5'h00, 2'd1, 1'b1, 1'b0);
    ex[3] = mk(4'b0010, 5'h15, 2'd1, 1'b1, 1'b0);
    ex[4] = mk(4'b0000, 5'h00, 2'd1, 1'b0, 1'b0);
    ex[5] = mk(4'b0000, 5'h00, 2'd1, 1'b0, 1'b0);
    ex[6] = mk(4'b0000, 5'h00, 2'd1, 1'b0, 1'b0);
    ex[7] = mk(4'b0000, 5'h00, 2'd1, 1'b0, 1'b0);
    ex[8] = mk(4'b1000, 5'h1e, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) drive(rq[i], fi[i], ex[i], 1'b0);
    for (int i = 0; sb_exp.size() != 0; i++) begin
      e = sb_exp.pop_front(); vec++;
      o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 13'bx;
      if (o !== e) begin miss++; $display("FAIL force_idle step %0d: got %s want %s", i, fmt(o), fmt(e)); end
    end
    idle_cycles(3);
  endtask

  // Long hold on the MAX_HOLD=256 instance: never released, timeout stays low
  task automatic test_long_hold();
    logic [12:0] o;
    logic [12:0] e;
    for (int i = 0; i < 12; i++)
      drive(4'b0001, 1'b0, mk(4'b0001, 5'h11, 2'd0, 1'b1, 1'b0), 1'b0);
    drive(4'b0000, 1'b0, mk(4'b0000, 5'h00, 2'd0, 1'b0, 1'b0), 1'b0);
    for (int i = 0; sb_exp.size() != 0; i++) begin
      e = sb_exp.pop_front(); vec++;
      o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 13'bx;
      if (o !== e) begin miss++; $display("FAIL long_hold step %0d: got %s want %s", i, fmt(o), fmt(e)); end
    end
    idle_cycles(3);
  endtask

`ifdef CTLMUX_TIMEOUT_EN
  // MAX_HOLD=8 instance: forced release after 8 owned cycles, blocked until req toggles
  task automatic test_timeout();
    logic [12:0] o;
    logic [12:0] e;
    for (int i = 0; i < 8; i++)
      drive(4'b0001, 1'b0, mk(4'b0001, 5'h11, 2'd0, 1'b1, 1'b0), 1'b1);
    drive(4'b0001, 1'b0, mk(4'b0000, 5'h00, 2'd0, 1'b0, 1'b1), 1'b1);
    for (int i = 0; i < 3; i++)
      drive(4'b0001, 1'b0, mk(4'b0000, 5'h00, 2'd0, 1'b0, 1'b0), 1'b1);
    drive(4'b0000, 1'b0, mk(4'b0000, 5'h00, 2'd0, 1'b0, 1'b0), 1'b1);
    drive(4'b0001, 1'b0, mk(4'b0001, 5'h11, 2'd0, 1'b1, 1'b0), 1'b1);
    for (int i = 0; sb_exp.size() != 0; i++) begin
      e = sb_exp.pop_front(); vec++;
      o = (sb_obs.size() != 0) ? sb_obs.pop_front() : 13'bx;
      if (o !== e) begin miss++; $display("FAIL timeout step %0d: got %s want %s", i, fmt(o), fmt(e)); end
    end
    idle_cycles(3);
  endtask
`endif

  initial begin
    vec        = 0;
    miss       = 0;
    reset_n    = 1'b0;
    req        = 4'b0000;
    force_idle = 1'b0;
    cv[0] = 5'h11;
    cv[1] = 5'h15;
    cv[2] = 5'h0a;
    cv[3] = 5'h1e;
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_force_idle();
    test_long_hold();
`ifdef CTLMUX_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
